// File: rtl/regfile_mp_sb_pkg.sv
// rtl/regfile_mp_sb_pkg.sv - shared register-file constants for ID-stage units
package regfile_mp_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int SP_ADDR_DEF = 29;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_0400;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: zero register, write-through bypass, busy masking
module rf_read_port
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic hit0;
  logic hit1;

  assign hit0 = we0 && (waddr0 == addr);
  assign hit1 = we1 && (waddr1 == addr);

  // Port 1 carries the younger producer, so it takes precedence over port 0.
  always_comb begin
    rdata = stored_data;
    if (addr == ADDR_W'(ZERO_REG)) rdata = '0;
    else if (hit1)                 rdata = wdata1;
    else if (hit0)                 rdata = wdata0;
  end

  // A write presented this cycle resolves the hazard through the bypass.
  assign rbusy = stored_busy && !hit0 && !hit1;

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with dual write, bypass and scoreboard
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int SP_ADDR = SP_ADDR_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DATA_W-1:0] rd_view [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_n;
  logic [ADDR_W:0]   busy_count_n;
  logic              issue_hit;
  logic              set_new;
  logic              clr0;
  logic              clr1;

  always_ff @(posedge clk) begin
    for (int r = 1; r < DEPTH; r++) begin
      if (reset)                                regs[r] <= (r == SP_ADDR) ? SP_INIT : '0;
      else if (we1 && waddr1 == ADDR_W'(r))     regs[r] <= wdata1;
      else if (we0 && waddr0 == ADDR_W'(r))     regs[r] <= wdata0;
    end
  end

  always_comb begin
    rd_view[0] = '0;
    for (int r = 1; r < DEPTH; r++) rd_view[r] = regs[r];
  end

  // A new producer issued on the same edge as a write keeps the register busy.
  always_comb begin
    busy_n = '0;
    for (int r = 1; r < DEPTH; r++) begin
      busy_n[r] = (issue_valid && issue_addr == ADDR_W'(r)) ||
                  (busy[r] && !(we0 && waddr0 == ADDR_W'(r)) && !(we1 && waddr1 == ADDR_W'(r)));
    end
  end

  // Incremental count; a register targeted by both write ports is only cleared once.
  always_comb begin
    issue_hit = issue_valid && (issue_addr != ADDR_W'(ZERO_REG));
    set_new   = issue_hit && !busy[issue_addr];
    clr0      = we0 && busy[waddr0] && !(issue_hit && issue_addr == waddr0);
    clr1      = we1 && busy[waddr1] && !(issue_hit && issue_addr == waddr1) &&
                !(we0 && waddr0 == waddr1);
    busy_count_n = busy_count + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr0) - (ADDR_W+1)'(clr1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_n;
      busy_count <= busy_count_n;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .addr        (raddr[k*ADDR_W +: ADDR_W]),
      .we0         (we0),
      .waddr0      (waddr0),
      .wdata0      (wdata0),
      .we1         (we1),
      .waddr1      (waddr1),
      .wdata1      (wdata1),
      .stored_data (rd_view[raddr[k*ADDR_W +: ADDR_W]]),
      .stored_busy (busy[raddr[k*ADDR_W +: ADDR_W]]),
      .rdata       (rdata[k*DATA_W +: DATA_W]),
      .rbusy       (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - scoreboard bench for regfile_mp_sb (32-bit and 16-bit instances)
module tb_regfile_mp_sb;

  localparam int NRD = 4;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              we0, we1, issue_valid;
  logic [AW-1:0]     waddr0, waddr1, issue_addr;
  logic [31:0]       wdata0, wdata1;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*32-1:0] rdata;
  logic [NRD*16-1:0] rdata16;
  logic [NRD-1:0]    rbusy, rbusy16;
  logic [AW:0]       busy_count, busy_count16;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .DATA_W(32), .ADDR_W(AW), .NUM_RD(NRD), .SP_ADDR(29), .SP_INIT(32'h0000_0400)
  ) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_count(busy_count)
  );

  regfile_mp_sb #(
    .DATA_W(16), .ADDR_W(AW), .NUM_RD(NRD), .SP_ADDR(29), .SP_INIT(16'h0400)
  ) dut16 (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0[15:0]),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1[15:0]),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .raddr(raddr), .rdata(rdata16), .rbusy(rbusy16), .busy_count(busy_count16)
  );

  typedef struct packed {
    logic [NRD*32-1:0] d;
    logic [NRD-1:0]    b;
    logic [AW:0]       cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mreg[32];
  bit          mbusy[32];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input int port, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s port=%0d t=%0t actual=%h required=%h", name, port, $time, act, req);
    end
  endtask

  function automatic int popcnt();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mbusy[r]);
    return n;
  endfunction

  function automatic logic [NRD*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mreg[r]  = (r == 29) ? 32'h0000_0400 : 32'h0;
      mbusy[r] = 1'b0;
    end
  endtask

  // Drive one cycle, queue what the outputs must be, then advance the model past the edge.
  task automatic cyc(input bit rst, input bit w0, input int a0, input logic [31:0] d0,
                     input bit w1, input int a1, input logic [31:0] d1,
                     input bit iv, input int ia, input logic [NRD*AW-1:0] ra);
    exp_t e;
    int   a;
    @(posedge clk);
    #1;
    reset = rst; we0 = w0; waddr0 = AW'(a0); wdata0 = d0;
    we1 = w1; waddr1 = AW'(a1); wdata1 = d1;
    issue_valid = iv; issue_addr = AW'(ia); raddr = ra;
    for (int k = 0; k < NRD; k++) begin
      a = int'(ra[k*AW +: AW]);
      if (a == 0)               e.d[k*32 +: 32] = 32'h0;
      else if (w1 && a1 == a)   e.d[k*32 +: 32] = d1;
      else if (w0 && a0 == a)   e.d[k*32 +: 32] = d0;
      else                      e.d[k*32 +: 32] = mreg[a];
      e.b[k] = mbusy[a] && !(w0 && a0 == a) && !(w1 && a1 == a);
    end
    e.cnt = (AW+1)'(popcnt());
    q.push_back(e);
    if (rst) model_reset();
    else begin
      if (w0 && a0 != 0) mreg[a0] = d0;
      if (w1 && a1 != 0) mreg[a1] = d1;
      if (w0) mbusy[a0] = 1'b0;
      if (w1) mbusy[a1] = 1'b0;
      if (iv && ia != 0) mbusy[ia] = 1'b1;
    end
  endtask

  task automatic idle(input logic [NRD*AW-1:0] ra);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, ra);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int k = 0; k < NRD; k++) begin
        check("rdata", k, rdata[k*32 +: 32], mon_e.d[k*32 +: 32]);
        check("rbusy", k, 32'(rbusy[k]), 32'(mon_e.b[k]));
        check("rdata16", k, 32'(rdata16[k*16 +: 16]), 32'(mon_e.d[k*32 +: 16]));
        check("rbusy16", k, 32'(rbusy16[k]), 32'(mon_e.b[k]));
      end
      check("busy_count", -1, 32'(busy_count), 32'(mon_e.cnt));
      check("busy_count16", -1, 32'(busy_count16), 32'(mon_e.cnt));
    end
  end

  function automatic int rand_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_addr = '0; raddr = '0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) idle(pk(4*i, 4*i+1, 4*i+2, 4*i+3));

    cyc(0, 1, 5, 32'h11, 1, 5, 32'h22, 0, 0, pk(5, 5, 0, 6));
    idle(pk(5, 5, 5, 5));
    cyc(0, 1, 0, 32'hdead, 0, 0, 32'h0, 0, 0, pk(0, 0, 5, 0));
    idle(pk(0, 5, 0, 0));

    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 7, pk(7, 7, 0, 29));
    idle(pk(7, 7, 7, 7));
    idle(pk(7, 6, 7, 8));
    cyc(0, 1, 7, 32'hA5, 0, 0, 32'h0, 0, 0, pk(7, 7, 7, 7));
    idle(pk(7, 7, 7, 7));

    cyc(0, 0, 0, 32'h0, 1, 9, 32'h99, 1, 9, pk(9, 9, 9, 9));
    idle(pk(9, 9, 9, 9));
    cyc(0, 0, 0, 32'h0, 1, 9, 32'h9A, 1, 9, pk(9, 9, 9, 9));
    idle(pk(9, 9, 9, 9));
    cyc(0, 1, 9, 32'h9B, 0, 0, 32'h0, 0, 0, pk(9, 9, 9, 9));

    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 3, pk(3, 4, 5, 29));
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 4, pk(3, 4, 5, 29));
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 5, pk(3, 4, 5, 29));
    cyc(1, 1, 29, 32'hBAD, 1, 4, 32'hBAD, 1, 6, pk(3, 4, 5, 29));
    idle(pk(3, 4, 5, 29));
    idle(pk(6, 4, 29, 0));

    cyc(0, 1, 6, 32'h66, 1, 5, 32'h55, 0, 0, pk(5, 6, 5, 0));
    cyc(0, 1, 5, 32'h77, 1, 6, 32'h88, 1, 5, pk(6, 5, 29, 6));
    idle(pk(6, 5, 29, 6));

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
          $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
          $urandom_range(0, 99) < 60, rand_addr(),
          pk(rand_addr(), rand_addr(), rand_addr(), rand_addr()));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) check("drain", -1, 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port register file for the pipelined CPU, successor to the single-write, two-read register file. Adds a configurable number of read ports, two write ports with defined same-address priority, write-through bypass on every read port, and a per-register scoreboard (busy bits plus outstanding-producer count). It sits in ID, feeding operands and hazard information to the hazard unit.

## Interface
- DATA_W, 32, data width of each register
- ADDR_W, 5, register address width; depth = 2^ADDR_W, register 0 hardwired zero
- NUM_RD, 2, number of read ports (1..4)
- SP_ADDR, 29, register given a non-zero reset value
- SP_INIT, 32'h00000400, reset value of register SP_ADDR

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0 (older producer)
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (younger producer)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- issue_valid  in  1  instruction with destination issued this cycle
- issue_addr  in  ADDR_W  destination register of issued instruction
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  per-port: addressed register has an outstanding producer
- busy_count  out  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: registers 1..2^ADDR_W-1; register 0 is not stored.
- Write: on edge, reg[waddr0] <= wdata0 if we0; reg[waddr1] <= wdata1 if we1. Same address on both: port 1 wins. Address 0 writes ignored.
- Read port k: addr 0 -> 0; else if we1 && waddr1==addr -> wdata1; else if we0 && waddr0==addr -> wdata0; else stored value. Fully combinational.
- Scoreboard busy[r], r>=1: set on edge when issue_valid && issue_addr==r; cleared on edge when any enabled write targets r. Set and clear same register same edge: set wins (new producer). issue to address 0 ignored; busy[0] always 0.
- rbusy[k] = busy[addr] && no enabled write to addr this cycle (write-through resolves it). Same-cycle issue does not affect rbusy until next cycle.
- busy_count: registered, equals population count of busy[] after each edge; updated incrementally (+1 on new set of non-busy reg, -1 per cleared reg, net of both writes and issue); range 0..2^ADDR_W-1, never wraps.

## Timing
- Reset (sync, edge with reset=1): all registers 0 except reg[SP_ADDR]=SP_INIT; all busy 0; busy_count 0. Writes and issue on that edge ignored. After reset, rdata = 0 for all addresses except SP_ADDR, rbusy = 0.
- Reset mid-operation discards all pending busy state; no write from the reset cycle survives.
- Write latency: visible on rdata in the same cycle (bypass) and from storage the cycle after.
- Scoreboard latency: issue at edge N -> rbusy high from cycle N+1 until the cycle a write to that register is presented (rbusy falls combinationally in that cycle).

## Structure
- Shared package: default parameter constants (DATA_W, ADDR_W, SP_ADDR, SP_INIT) and a ZERO_REG constant, reused by hazard unit and forwarding unit.
- One sub-module, rf_read_port: address-zero check, two-level write bypass, busy masking; instantiated NUM_RD times via generate.
- Scoreboard and busy_count kept in top level.

## Test plan
- Reset, then read all 32 addresses -> reg 29 reads 32'h400, all others 0, busy_count 0.
- we0 & we1 both to r5 with 32'h11/32'h22 -> rdata 32'h22 same cycle, stored 32'h22 next cycle; write to r0 -> r0 still reads 0.
- issue r7 at edge N -> rbusy=1 cycles N+1..; we0 to r7 with 32'hA5 -> rbusy=0 and rdata=32'hA5 same cycle; busy_count 1 -> 0.
- issue r9 and we1 r9 same cycle -> r9 busy afterwards, busy_count unchanged at 1 if already busy, else +1.
- issue r3, r4, r5 on consecutive cycles, assert reset while r4 busy -> all busy cleared, busy_count 0, reg 29 = 32'h400.
- NUM_RD=4, DATA_W=16: four ports read distinct/same addresses with concurrent writes -> each port bypasses independently.
